// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, occupancy count, sticky errors and flush; SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     write_enable,
  input  logic                     read_enable,
  input  logic [DATA_WIDTH-1:0]    datain,
  output logic [DATA_WIDTH-1:0]    dataout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL > DEPTH) begin : g_af_chk
    $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_ae_chk
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic rd_acc, wr_acc;

  // accept decisions and next occupancy; a flush forces the next count to zero
  always_comb begin
    rd_acc = read_enable && !empty;
    wr_acc = write_enable && (!full || rd_acc);
    count_nxt = clear ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
  end

  // storage array is deliberately left unreset; writes are blocked during flush and reset
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_acc) mem[wr_ptr] <= datain;
  end

  // pointers, count, registered flags and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= clear ? '0 : wr_ptr + AW'(wr_acc);
      rd_ptr <= clear ? '0 : rd_ptr + AW'(rd_acc);
      count <= count_nxt;
      empty <= count_nxt == '0;
      full <= count_nxt == DEPTH_C;
      almost_empty <= count_nxt <= AE_C;
      almost_full <= count_nxt >= AF_C;
      overflow <= clear ? 1'b0 : overflow || (write_enable && !wr_acc);
      underflow <= clear ? 1'b0 : underflow || (read_enable && empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dataout = empty ? '0 : mem[rd_ptr];
`else
  // registered read port holds its value unless a read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dataout <= '0;
    else if (!clear && rd_acc) dataout <= mem[rd_ptr];
  end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table, directed corner sequences and random traffic against a queue model
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst, clear, we, re;
  logic [7:0] din;
  logic [7:0] dout;
  logic full, empty, af, ae, ovf, unf;
  logic [4:0] count;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] dout_m;
  logic ovf_m, unf_m;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .write_enable(we), .read_enable(re),
    .datain(din), .dataout(dout), .full(full), .empty(empty), .almost_full(af),
    .almost_empty(ae), .count(count), .overflow(ovf), .underflow(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic w;
    logic r;
    logic [7:0] d;
    int cnt;
    logic [7:0] ds;
    logic [7:0] df;
    logic e;
  } vec_t;
  vec_t tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return q.size() > 0 ? q[0] : 8'h00;
`else
    return dout_m;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    dout_m = 8'h00;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic model_edge();
    logic rd_ok, wr_ok;
    if (clear) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      rd_ok = re && q.size() > 0;
      wr_ok = we && (q.size() < DEPTH || rd_ok);
      if (re && q.size() == 0) unf_m = 1'b1;
      if (we && !wr_ok) ovf_m = 1'b1;
      if (rd_ok) dout_m = q.pop_front();
      if (wr_ok) q.push_back(din);
    end
  endtask

  task automatic check_model();
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", af, q.size() >= DEPTH - 2);
    chk("almost_empty", ae, q.size() <= 2);
    chk("overflow", ovf, ovf_m);
    chk("underflow", unf, unf_m);
    chk("dataout", dout, exp_dout());
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    we = w;
    re = r;
    clear = c;
    din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    we = 1'b0;
    re = 1'b0;
    clear = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, base + 8'(i));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int bias;
    rst = 1'b1;
    clear = 1'b0;
    we = 1'b0;
    re = 1'b0;
    din = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", ae, 1);
    chk("rst_af", af, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);

    tv[0] = '{1'b1, 1'b0, 8'h0A, 1, 8'h00, 8'h0A, 1'b0};
    tv[1] = '{1'b1, 1'b0, 8'h0D, 2, 8'h00, 8'h0A, 1'b0};
    tv[2] = '{1'b0, 1'b1, 8'h00, 1, 8'h0A, 8'h0D, 1'b0};
    tv[3] = '{1'b0, 1'b1, 8'h00, 0, 8'h0D, 8'h00, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(tv[i].w, tv[i].r, 1'b0, tv[i].d);
      chk("tbl_count", count, tv[i].cnt);
      chk("tbl_empty", empty, tv[i].e);
`ifdef SYNC_FIFO_FWFT_EN
      chk("tbl_dout", dout, tv[i].df);
`else
      chk("tbl_dout", dout, tv[i].ds);
`endif
    end

    fill(13, 8'h00);
    chk("af_at13", af, 0);
    fill(1, 8'h0D);
    chk("af_at14", af, 1);
    fill(2, 8'h0E);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("fill_ovf", ovf, 1);
    chk("fill_count_after_ovf", count, 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      chk("fill_order", dout, i);
`endif
    end

    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clear_ovf", ovf, 0);
    fill(10, 8'h20);
    drain(10);
    fill(12, 8'h40);
    chk("wrap_max", count, 12);
    drain(12);
    chk("wrap_empty", empty, 1);

    fill(16, 8'h60);
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("simul_full_count", count, 16);
    chk("simul_full_full", full, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("simul_full_oldest", dout, 8'h60);
`endif
    drain(16);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("simul_empty_count", count, 1);
    chk("simul_empty_unf", unf, 1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("simul_empty_data", dout, 8'h55);
`endif

    step(1'b0, 1'b0, 1'b1, 8'h00);
    fill(16, 8'h80);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    drain(11);
    chk("pre_clear_count", count, 5);
    chk("pre_clear_ovf", ovf, 1);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    chk("clear_count", count, 0);
    chk("clear_empty", empty, 1);
    chk("clear_ovf2", ovf, 0);
    chk("clear_unf", unf, 0);

    fill(3, 8'h30);
    we = 1'b1;
    din = 8'h33;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model();
    chk("async_count", count, 0);
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;
    we = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h7A);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_visible", dout, 8'h7A);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_pop_dout", dout, 0);
`else
    chk("after_rst_data", dout, 8'h7A);
`endif
    chk("after_rst_empty", empty, 1);

    bias = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = (bias == 30) ? 75 : 30;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias, $urandom_range(0, 99) == 0,
           8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
